// File: rtl/ntt_sched_pkg.sv
// rtl/ntt_sched_pkg.sv - shared state encoding, defaults and width helper for the NTT scheduler
package ntt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    START,
    FEED,
    WAIT,
    DRAIN
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_LEN  = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ntt_stream_scheduler_rr_arbiter.sv
// rtl/ntt_stream_scheduler_rr_arbiter.sv - round-robin pick of the first request at or after the pointer
module rr_arbiter
  import ntt_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    ptr,
  output logic                            found,
  output logic [NUM_REQ-1:0]              grant,
  output logic [id_width(NUM_REQ)-1:0]    index
);

  localparam int IDW = id_width(NUM_REQ);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    grant = '0;
    index = '0;
    if (enable) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        j = (int'(ptr) + off) % NUM_REQ;
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          index    = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ntt_stream_scheduler.sv
// rtl/ntt_stream_scheduler.sv - arbitrates requesters onto one NTT core, buffering each block so it can be fed back-to-back
module ntt_stream_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_LEN  = DEF_BLOCK_LEN,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            ntt_start,
  output logic [DATA_WIDTH-1:0]           ntt_in_stream,
  input  logic                            ntt_ready,
  input  logic [DATA_WIDTH-1:0]           ntt_out_stream,
  output logic                            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic [id_width(NUM_REQ)-1:0]    resp_id,
  output logic                            resp_last,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = id_width(BLOCK_LEN);
  localparam int TW  = id_width(TIMEOUT);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(BLOCK_LEN - 1);
  localparam logic [TW-1:0]  LAST_TICK = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_REQ  = IDW'(NUM_REQ - 1);

  state_t                  state, state_nx;
  logic [IDW-1:0]          owner, rr_ptr, arb_index;
  logic [NUM_REQ-1:0]      arb_grant;
  logic                    arb_found;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tcnt;
  logic [DATA_WIDTH-1:0]   blk_buf [BLOCK_LEN];
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .enable (state == IDLE),
    .req    (req),
    .ptr    (rr_ptr),
    .found  (arb_found),
    .grant  (arb_grant),
    .index  (arb_index)
  );

  assign owner_data = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign accept     = (state == COLLECT) && req_valid[owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req_ready     = '0;
    ntt_start     = 1'b0;
    ntt_in_stream = '0;
    busy          = (state != IDLE);
    case (state)
      IDLE:    if (arb_found) state_nx = COLLECT;
      COLLECT: begin
        req_ready = grant;
        if (accept && cnt == LAST_IDX) state_nx = START;
      end
      START: begin
        ntt_start = 1'b1;
        state_nx  = FEED;
      end
      FEED: begin
        ntt_in_stream = blk_buf[cnt];
        if (cnt == LAST_IDX) state_nx = WAIT;
      end
      WAIT: begin
        if (ntt_ready)               state_nx = DRAIN;
        else if (tcnt == LAST_TICK)  state_nx = IDLE;
      end
      DRAIN:   if (cnt == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drain is count-based: once the first result word shows up, the NTT streams the rest unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_id     <= '0;
      resp_last   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < BLOCK_LEN; i++) blk_buf[i] <= '0;
    end else begin
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_last   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant  <= arb_grant;
            owner  <= arb_index;
            rr_ptr <= (arb_index == LAST_REQ) ? '0 : arb_index + 1'b1;
            cnt    <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            blk_buf[cnt] <= owner_data;
            cnt          <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          end
        end
        START: cnt <= '0;
        FEED: begin
          cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          tcnt <= '0;
        end
        WAIT: begin
          if (ntt_ready) begin
            resp_valid <= 1'b1;
            resp_data  <= ntt_out_stream;
            resp_id    <= owner;
            resp_last  <= (LAST_IDX == '0);
            cnt        <= CW'(1);
          end else if (tcnt == LAST_TICK) begin
            timeout_err <= 1'b1;
            grant       <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          resp_valid <= 1'b1;
          resp_data  <= ntt_out_stream;
          resp_id    <= owner;
          resp_last  <= (cnt == LAST_IDX);
          cnt        <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          if (cnt == LAST_IDX) grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
